// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control FSM: states, opcodes, ALU and mux selects.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecuteR = 4'd6,
      StExecuteI = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10,
      StTrap     = 4'd11
   } state_e;

   localparam logic [6:0] OpLw    = 7'b0000011;
   localparam logic [6:0] OpSw    = 7'b0100011;
   localparam logic [6:0] OpRType = 7'b0110011;
   localparam logic [6:0] OpIType = 7'b0010011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10
   } alu_op_e;

   typedef enum logic [2:0] {
      AluAdd = 3'b000,
      AluSub = 3'b001,
      AluAnd = 3'b010,
      AluOr  = 3'b011,
      AluSlt = 3'b101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ResAluOut    = 2'b00,
      ResMemData   = 2'b01,
      ResAluResult = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      SrcAPc    = 2'b00,
      SrcAOldPc = 2'b01,
      SrcARs1   = 2'b10
   } src_a_e;

   typedef enum logic [1:0] {
      SrcBRs2  = 2'b00,
      SrcBImm  = 2'b01,
      SrcBFour = 2'b10
   } src_b_e;

   localparam logic [1:0] ImmI = 2'b00;
   localparam logic [1:0] ImmS = 2'b01;
   localparam logic [1:0] ImmB = 2'b10;
   localparam logic [1:0] ImmJ = 2'b11;

   function automatic logic [1:0] imm_src_of(logic [6:0] op);
      logic [1:0] imm;
      case (op)
         OpSw:    imm = ImmS;
         OpBeq:   imm = ImmB;
         OpJal:   imm = ImmJ;
         default: imm = ImmI;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath.
interface multicycle_controller_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;

   logic       MemReq;
   logic       MemWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic       Halted;

   modport master (
      input  op, funct3, funct7b5, Zero, MemReady,
      output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Halted
   );

   modport slave (
      output op, funct3, funct7b5, Zero, MemReady,
      input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Halted
   );

endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction funct fields onto the ALU operation select.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  alu_op_e    alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       op5_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      alu_control_o = AluAdd;
      unique case (alu_op_i)
         AluOpAdd: alu_control_o = AluAdd;
         AluOpSub: alu_control_o = AluSub;
         AluOpFunct: begin
            case (funct3_i)
               // Only R-type honours funct7b5; addi with imm[10] set must stay an add.
               3'b000:  alu_control_o = (op5_i & funct7b5_i) ? AluSub : AluAdd;
               3'b010:  alu_control_o = AluSlt;
               3'b110:  alu_control_o = AluOr;
               3'b111:  alu_control_o = AluAnd;
               default: alu_control_o = AluAdd;
            endcase
         end
         default: alu_control_o = AluAdd;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute, stalls on MemReady, traps on
// unsupported opcodes.
module multicycle_controller
   import rv_ctrl_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RESET,
   multicycle_controller_if.master bus
);

   state_e      state_q, state_d;
   logic        mem_req, mem_write, adr_src, ir_write, pc_update, branch, reg_write, halted;
   result_src_e result_src;
   src_a_e      src_a;
   src_b_e      src_b;
   alu_op_e     alu_op;
   logic [2:0]  alu_control;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:    if (bus.MemReady) state_d = StDecode;
         StDecode: begin
            case (bus.op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRType:    state_d = StExecuteR;
               OpIType:    state_d = StExecuteI;
               OpBeq:      state_d = StBeq;
               OpJal:      state_d = StJal;
               default:    state_d = StTrap;
            endcase
         end
         StMemAdr:   state_d = (bus.op == OpSw) ? StMemWrite : StMemRead;
         StMemRead:  if (bus.MemReady) state_d = StMemWb;
         StMemWrite: if (bus.MemReady) state_d = StFetch;
         StMemWb:    state_d = StFetch;
         StExecuteR: state_d = StAluWb;
         StExecuteI: state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StBeq:      state_d = StFetch;
         // ALUOut already holds OldPC+4 after JAL, so ALUWB completes the link write.
         StJal:      state_d = StAluWb;
         StTrap:     state_d = StTrap;
         default:    state_d = StTrap;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      halted     = 1'b0;
      result_src = ResAluOut;
      src_a      = SrcAPc;
      src_b      = SrcBRs2;
      alu_op     = AluOpAdd;
      unique case (state_q)
         StFetch: begin
            mem_req    = 1'b1;
            src_b      = SrcBFour;
            result_src = ResAluResult;
            ir_write   = bus.MemReady;
            pc_update  = bus.MemReady;
         end
         StDecode: begin
            src_a = SrcAOldPc;
            src_b = SrcBImm;
         end
         StMemAdr: begin
            src_a = SrcARs1;
            src_b = SrcBImm;
         end
         StMemRead: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         StMemWrite: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         StMemWb: begin
            result_src = ResMemData;
            reg_write  = 1'b1;
         end
         StExecuteR: begin
            src_a  = SrcARs1;
            alu_op = AluOpFunct;
         end
         StExecuteI: begin
            src_a  = SrcARs1;
            src_b  = SrcBImm;
            alu_op = AluOpFunct;
         end
         StAluWb:    reg_write = 1'b1;
         StBeq: begin
            src_a  = SrcARs1;
            alu_op = AluOpSub;
            branch = 1'b1;
         end
         StJal: begin
            src_a     = SrcAOldPc;
            src_b     = SrcBFour;
            pc_update = 1'b1;
         end
         StTrap:     halted = 1'b1;
         default:    halted = 1'b1;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (bus.funct3),
      .op5_i         (bus.op[5]),
      .funct7b5_i    (bus.funct7b5),
      .alu_control_o (alu_control)
   );

   // Enables are gated by RESET so nothing commits while the FSM is being reset.
   assign bus.MemReq     = RESET & mem_req;
   assign bus.MemWrite   = RESET & mem_write;
   assign bus.IRWrite    = RESET & ir_write;
   assign bus.PCWrite    = RESET & (pc_update | (branch & bus.Zero));
   assign bus.RegWrite   = RESET & reg_write;
   assign bus.AdrSrc     = adr_src;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ImmSrc     = imm_src_of(bus.op);
   assign bus.ALUControl = alu_control;
   assign bus.Halted     = halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: builds each instruction's expected cycle list from its class and wait counts.
module tb_multicycle_controller;

   logic CLK;
   logic RESET;
   int   vectors;
   int   miscompares;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef enum {PFetch, PDecode, PMemAdr, PMemRead, PMemWrite, PMemWb,
                 PExecR, PExecI, PAluWb, PBeq, PJal, PTrap} phase_e;
   typedef struct {
      phase_e ph;
      bit     ready;
   } step_t;

   step_t      steps[$];
   logic [6:0] op_v;
   logic [2:0] f3_v;
   bit         f7_v;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

   function automatic logic [2:0] ref_alu(logic [2:0] f3, logic [6:0] op, bit f7);
      case (f3)
         3'd0:    return (op[5] && f7) ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] ref_imm(logic [6:0] op);
      if (op == SW) return 2'b01;
      if (op == BQ) return 2'b10;
      if (op == JL) return 2'b11;
      return 2'b00;
   endfunction

   // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUCtl,Halted}
   function automatic logic [17:0] model(phase_e ph, bit rdy, bit z, logic [6:0] op,
                                         logic [2:0] f3, bit f7);
      logic       mreq = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, halt = 0;
      logic [1:0] rsrc = 0, a = 0, b = 0;
      logic [2:0] ctl = 0;
      case (ph)
         PFetch:    begin mreq = 1; rsrc = 2'b10; b = 2'b10; irw = rdy; pcw = rdy; end
         PDecode:   begin a = 2'b01; b = 2'b01; end
         PMemAdr:   begin a = 2'b10; b = 2'b01; end
         PMemRead:  begin mreq = 1; adr = 1; end
         PMemWrite: begin mreq = 1; adr = 1; mw = 1; end
         PMemWb:    begin rsrc = 2'b01; rw = 1; end
         PExecR:    begin a = 2'b10; ctl = ref_alu(f3, op, f7); end
         PExecI:    begin a = 2'b10; b = 2'b01; ctl = ref_alu(f3, op, f7); end
         PAluWb:    rw = 1;
         PBeq:      begin a = 2'b10; ctl = 3'b001; pcw = z; end
         PJal:      begin a = 2'b01; b = 2'b10; pcw = 1; end
         PTrap:     halt = 1;
         default:   halt = 1;
      endcase
      return {mreq, mw, adr, irw, pcw, rw, rsrc, a, b, ref_imm(op), ctl, halt};
   endfunction

   function automatic logic [17:0] observed();
      return {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
              bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.Halted};
   endfunction

   function automatic void push_wait(phase_e ph, int waits);
      for (int i = 0; i < waits; i++) steps.push_back('{ph, 1'b0});
      steps.push_back('{ph, 1'b1});
   endfunction

   // Expected cycle list of one instruction, from its class and the memory wait counts.
   function automatic void build_instr(logic [6:0] op, int fw, int mw);
      steps.delete();
      push_wait(PFetch, fw);
      steps.push_back('{PDecode, 1'b0});
      case (op)
         LW: begin
            steps.push_back('{PMemAdr, 1'b0});
            push_wait(PMemRead, mw);
            steps.push_back('{PMemWb, 1'b0});
         end
         SW: begin
            steps.push_back('{PMemAdr, 1'b0});
            push_wait(PMemWrite, mw);
         end
         RT: begin steps.push_back('{PExecR, 1'b0}); steps.push_back('{PAluWb, 1'b0}); end
         IT: begin steps.push_back('{PExecI, 1'b0}); steps.push_back('{PAluWb, 1'b0}); end
         BQ: steps.push_back('{PBeq, 1'b0});
         JL: begin steps.push_back('{PJal, 1'b0}); steps.push_back('{PAluWb, 1'b0}); end
         default: for (int i = 0; i < 10; i++) steps.push_back('{PTrap, 1'b0});
      endcase
   endfunction

   task automatic apply_steps(string name, logic [6:0] op, logic [2:0] f3, bit f7,
                              bit fixed_zero, bit zval);
      logic [17:0] exp_v, got_v;
      bit          z;
      for (int i = 0; i < steps.size(); i++) begin
         @(negedge CLK);
         op_v = op; f3_v = f3; f7_v = f7;
         bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
         z = fixed_zero ? zval : 1'($urandom_range(0, 1));
         bus.Zero = z;
         bus.MemReady = steps[i].ready;
         #1;
         exp_v = model(steps[i].ph, steps[i].ready, z, op, f3, f7);
         got_v = observed();
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s cycle %0d (%s): got %h expected %h", name, i,
                     steps[i].ph.name(), got_v, exp_v);
         end
      end
   endtask

   task automatic run_instr(string name, logic [6:0] op, logic [2:0] f3, bit f7,
                            int fw, int mw, bit fixed_zero, bit zval);
      build_instr(op, fw, mw);
      apply_steps(name, op, f3, f7, fixed_zero, zval);
   endtask

   // Reset pulse from any state: enables low during reset, then FETCH with Halted clear.
   task automatic reset_pulse(string name);
      logic [4:0]  en;
      logic [17:0] exp_v;
      @(negedge CLK);
      RESET = 1'b0;
      bus.MemReady = 1'($urandom_range(0, 1));
      bus.Zero = 1'b1;
      #1;
      en = {bus.MemReq, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite};
      vectors++;
      if (en !== 5'b0) begin
         miscompares++;
         $display("FAIL %s enables during reset: got %b expected 00000", name, en);
      end
      @(negedge CLK);
      RESET = 1'b1;
      bus.MemReady = 1'b0;
      #1;
      exp_v = model(PFetch, 1'b0, 1'b0, op_v, f3_v, f7_v);
      vectors++;
      if (observed() !== exp_v) begin
         miscompares++;
         $display("FAIL %s fetch after reset: got %h expected %h", name, observed(), exp_v);
      end
   endtask

   task automatic test_reset();
      logic [4:0] en;
      RESET = 1'b0;
      bus.MemReady = 1'b1;
      bus.Zero = 1'b1;
      op_v = RT; f3_v = 3'd0; f7_v = 1'b0;
      bus.op = op_v; bus.funct3 = f3_v; bus.funct7b5 = f7_v;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         #1;
         en = {bus.MemReq, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite};
         vectors++;
         if (en !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_hold cycle %0d: got %b expected 00000", i, en);
         end
      end
      reset_pulse("reset_release");
   endtask

   task automatic test_alu_r();
      run_instr("add", RT, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
      run_instr("sub", RT, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
      run_instr("addi_f7", IT, 3'd0, 1'b1, 1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_lw_stall();
      run_instr("lw_stall", LW, 3'd2, 1'b0, 0, 2, 1'b0, 1'b0);
      run_instr("sw_stall", SW, 3'd2, 1'b0, 1, 2, 1'b0, 1'b0);
   endtask

   task automatic test_beq();
      run_instr("beq_taken", BQ, 3'd0, 1'b0, 0, 0, 1'b1, 1'b1);
      run_instr("beq_not_taken", BQ, 3'd0, 1'b0, 0, 0, 1'b1, 1'b0);
      run_instr("jal", JL, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [6];
      logic [6:0] op;
      ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BQ; ops[5] = JL;
      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 5)];
         run_instr("random", op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0);
      end
   endtask

   task automatic test_stall_reset();
      steps.delete();
      push_wait(PFetch, 0);
      steps.push_back('{PDecode, 1'b0});
      steps.push_back('{PMemAdr, 1'b0});
      steps.push_back('{PMemRead, 1'b0});
      steps.push_back('{PMemRead, 1'b0});
      apply_steps("lw_partial", LW, 3'd2, 1'b0, 1'b0, 1'b0);
      reset_pulse("reset_mid_stall");
      run_instr("or_after_reset", RT, 3'd6, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_trap();
      run_instr("trap", 7'b0000000, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
      reset_pulse("trap_reset");
      run_instr("and_after_trap", IT, 3'd7, 1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_alu_r();
      test_lw_stall();
      test_beq();
      test_back_to_back();
      test_stall_reset();
      test_trap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
